uart_bus_master: RTL and testbench

- Serial-to-bus bridge: receives 8N1 command frames on rxd and issues single-word bus cycles as initiator on the same stb/ack/we/sel bus our peripheral slaves respond on.
- Returns results on txd.
- Used as a host debug/loader port driving the system bus, including our UART slave and memories, from a PC.

---
 rtl/uart_bus_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// Serial-to-bus bridge: 8N1 'W'/'R' command frames on rxd become single-word stb/ack bus cycles, replies go out on txd.
// Optional macro UBM_BUSTIMEOUT_EN aborts a bus cycle after TIMEOUT clocks without ack and replies 'E'.
module uart_bus_master #(
  parameter int DIV     = 24,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        busy_o
);

  localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV >> 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  // ---------------- RX deserializer ----------------
  logic [1:0]    rx_sync;
  logic          rx_active;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_valid;
  logic          rx_ferr;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_sync   <= 2'b11;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (!rx_sync[1]) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
        end
      end else begin
        if (rx_cnt == CNT_MAX) begin
          rx_cnt <= '0;
          rx_bit <= rx_bit + 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
        // Mid-bit sample: bit 0 is start, 1..8 data, 9 stop
        if (rx_cnt == CNT_HALF) begin
          if (rx_bit == 4'd0) begin
            if (rx_sync[1]) rx_active <= 1'b0;
          end else if (rx_bit == 4'd9) begin
            rx_active <= 1'b0;
            if (rx_sync[1]) rx_valid <= 1'b1;
            else            rx_ferr  <= 1'b1;
          end else begin
            rx_sh <= {rx_sync[1], rx_sh[7:1]};
          end
        end
      end
    end
  end

  // ---------------- TX serializer ----------------
  logic          tx_active;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic          tx_load;
  logic          tx_stop_end;
  logic [31:0]   rsp_buf;

  assign tx_stop_end = tx_active && (tx_cnt == CNT_MAX) && (tx_bit == 4'd9);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      txd       <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
    end else if (tx_load) begin
      txd       <= 1'b0;
      tx_sh     <= {1'b1, rsp_buf[31:24]};
      tx_active <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (tx_active) begin
      if (tx_cnt == CNT_MAX) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          txd    <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- Command parser / bus initiator ----------------
  state_t        state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [1:0]    resp_cnt;
  logic          tx_go;
  logic          bus_latch;
  logic          bus_err;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  // First reply byte is requested by tx_go; later ones chain onto the previous stop bit
  assign tx_load = (state == RESP) && (tx_go || (tx_stop_end && resp_cnt != 2'd0));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      resp_cnt  <= '0;
      tx_go     <= 1'b0;
      bus_latch <= 1'b0;
      bus_err   <= 1'b0;
      tmo_cnt   <= '0;
      rsp_buf   <= '0;
      adr_o     <= '0;
      dat_o     <= '0;
      sel_o     <= '0;
      we_o      <= 1'b0;
      stb_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      if (tx_load) rsp_buf <= {rsp_buf[23:0], 8'h00};
      case (state)
        IDLE: begin
          if (rx_valid && (rx_sh == CMD_W || rx_sh == CMD_R)) begin
            is_write <= (rx_sh == CMD_W);
            busy_o   <= 1'b1;
            byte_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (rx_ferr) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (rx_valid) begin
            adr_o <= {adr_o[23:0], rx_sh};
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              if (is_write) begin
                state <= DATA;
              end else begin
                state     <= BUS;
                stb_o     <= 1'b1;
                sel_o     <= 4'b1111;
                we_o      <= 1'b0;
                tmo_cnt   <= '0;
                bus_latch <= 1'b0;
                bus_err   <= 1'b0;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        DATA: begin
          if (rx_ferr) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (rx_valid) begin
            dat_o <= {dat_o[23:0], rx_sh};
            if (byte_cnt == 2'd3) begin
              byte_cnt  <= '0;
              state     <= BUS;
              stb_o     <= 1'b1;
              sel_o     <= 4'b1111;
              we_o      <= 1'b1;
              tmo_cnt   <= '0;
              bus_latch <= 1'b0;
              bus_err   <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        BUS: begin
          if (bus_latch) begin
            // Slave data is valid one cycle after its ack edge
            bus_latch <= 1'b0;
            tx_go     <= 1'b1;
            state     <= RESP;
            if (bus_err) begin
              rsp_buf  <= {RSP_E, 24'h0};
              resp_cnt <= 2'd0;
            end else if (is_write) begin
              rsp_buf  <= {RSP_K, 24'h0};
              resp_cnt <= 2'd0;
            end else begin
              rsp_buf  <= dat_i;
              resp_cnt <= 2'd3;
            end
          end else begin
            if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            if (ack_i) begin
              stb_o     <= 1'b0;
              we_o      <= 1'b0;
              sel_o     <= '0;
              bus_latch <= 1'b1;
            end
`ifdef UBM_BUSTIMEOUT_EN
            else if (tmo_hit) begin
              stb_o     <= 1'b0;
              we_o      <= 1'b0;
              sel_o     <= '0;
              bus_latch <= 1'b1;
              bus_err   <= 1'b1;
            end
`else
`endif
          end
        end
        RESP: begin
          if (tx_go) begin
            tx_go <= 1'b0;
          end else if (tx_stop_end) begin
            if (resp_cnt != 2'd0) begin
              resp_cnt <= resp_cnt - 2'd1;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: commands driven on rxd, bus slave model, txd frame decoder.
module tb_uart_bus_master;
  localparam int DIV    = 3;
  localparam int BITCLK = DIV + 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, busy_o;
  logic        ack_i;
  logic [31:0] dat_i = '0;
  logic        ack_en = 1'b1;
  logic [31:0] slave_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign ack_i = stb_o & ack_en;

  always #5 clk = ~clk;

  uart_bus_master #(.DIV(DIV), .TIMEOUT(8)) dut (
    .clk(clk), .rst_i(rst_i), .rxd(rxd), .txd(txd),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o),
    .ack_i(ack_i), .dat_i(dat_i), .busy_o(busy_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: acks in the strobe cycle, registers read data at that edge
  int          stb_cnt = 0;
  logic [31:0] last_adr = '0, last_dat = '0;
  logic [3:0]  last_sel = '0;
  logic        last_we = 1'b0;
  always @(posedge clk) begin
    if (stb_o === 1'b1) begin
      stb_cnt  <= stb_cnt + 1;
      last_adr <= adr_o;
      last_dat <= dat_o;
      last_sel <= sel_o;
      last_we  <= we_o;
      if (ack_en) dat_i <= slave_rdata;
    end
  end

  // txd frame decoder
  int         mon_n = 0;
  logic [7:0] mon_byte [64];
  logic       mon_stop [64];
  logic       mon_busy [64];
  int         mon_t    [64];
  initial begin
    logic [7:0] b;
    int t;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        t = cyc;
        @(negedge clk);
        if (txd === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BITCLK) @(negedge clk);
            b[i] = txd;
          end
          repeat (BITCLK) @(negedge clk);
          if (mon_n < 64) begin
            mon_byte[mon_n] = b;
            mon_stop[mon_n] = txd;
            mon_busy[mon_n] = busy_o;
            mon_t[mon_n]    = t;
          end
          mon_n++;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int rd_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    rxd = stop;
    repeat (BITCLK) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (mon_n < rd_idx + n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(mon_n >= rd_idx + n), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    check({tag, "_byte"}, 32'(mon_byte[rd_idx]), 32'(exp));
    check({tag, "_stop"}, 32'(mon_stop[rd_idx]), 32'd1);
    check({tag, "_busy"}, 32'(mon_busy[rd_idx]), 32'd1);
    rd_idx++;
  endtask

  task automatic expect_read(input string tag, input logic [31:0] w);
    for (int i = 0; i < 4; i++) expect_byte(tag, w[31-8*i -: 8]);
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {txd, stb_o, we_o, sel_o, busy_o}, 32'b1_0_0_0000_0);
    check("reset_adr", adr_o, 32'h0);
    check("reset_dat", dat_o, 32'h0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ctl", {txd, stb_o, busy_o}, 32'b100);

    // Write 0x41 to word address 2
    s0 = stb_cnt;
    send_byte(8'h57, 1'b1);
    repeat (3) @(negedge clk);
    check("wr_busy_rise", busy_o, 1'b1);
    send_word(32'h0000_0002);
    send_word(32'h0000_0041);
    wait_bytes(1, "wr_resp_wait");
    check("wr_stb_cycles", stb_cnt - s0, 32'd1);
    check("wr_we", last_we, 1'b1);
    check("wr_adr", last_adr, 32'h2);
    check("wr_dat", last_dat, 32'h41);
    check("wr_sel", last_sel, 4'hF);
    expect_byte("wr_k", 8'h4B);
    repeat (4) @(negedge clk);
    check("wr_busy_fall", {busy_o, txd}, 32'b01);

    // Read word address 1, reply 4 bytes back-to-back
    slave_rdata = 32'h1234_5678;
    s0 = stb_cnt;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0001);
    wait_bytes(4, "rd_resp_wait");
    check("rd_stb_cycles", stb_cnt - s0, 32'd1);
    check("rd_we", last_we, 1'b0);
    check("rd_adr", last_adr, 32'h1);
    for (int i = 1; i < 4; i++)
      check("rd_gap", 32'(mon_t[rd_idx+i] - mon_t[rd_idx+i-1]), 32'd40);
    expect_read("rd", 32'h1234_5678);
    repeat (4) @(negedge clk);
    check("rd_busy_fall", busy_o, 1'b0);

    // One-clock glitch on rxd
    s0 = stb_cnt;
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy", busy_o, 1'b0);
    check("glitch_nobyte", 32'(mon_n - rd_idx), 32'd0);
    check("glitch_nostb", stb_cnt - s0, 32'd0);

    // Garbage bytes then a valid read
    send_byte(8'h00, 1'b1);
    send_byte(8'h41, 1'b1);
    repeat (3) @(negedge clk);
    check("garbage_busy", busy_o, 1'b0);
    slave_rdata = 32'hA1B2_C3D4;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0005);
    wait_bytes(4, "garb_resp_wait");
    check("garb_stb_cycles", stb_cnt - s0, 32'd1);
    check("garb_adr", last_adr, 32'h5);
    expect_read("garb", 32'hA1B2_C3D4);

    // Framing error aborts a half-received command
    repeat (10) @(negedge clk);
    s0 = stb_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_busy", busy_o, 1'b0);
    check("ferr_nostb", stb_cnt - s0, 32'd0);
    slave_rdata = 32'hCAFE_F00D;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0003);
    wait_bytes(4, "ferr_resp_wait");
    check("ferr_stb_cycles", stb_cnt - s0, 32'd1);
    check("ferr_adr", last_adr, 32'h3);
    check("ferr_we", last_we, 1'b0);
    expect_read("ferr", 32'hCAFE_F00D);

    // Asynchronous reset during the second reply byte
    repeat (10) @(negedge clk);
    slave_rdata = 32'h1122_3344;
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0004);
    wait_bytes(1, "rst_resp_wait");
    repeat (10) @(negedge clk);
    check("rst_pre_txd", txd, 1'b0);
    #3 rst_i = 1'b1;
    #1 check("rst_async", {txd, busy_o, stb_o}, 32'b100);
    @(negedge clk) rst_i = 1'b0;
    repeat (50) @(negedge clk);
    rd_idx = mon_n;
    check("rst_idle", {txd, busy_o}, 32'b10);
    s0 = stb_cnt;
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0007);
    send_word(32'hDEAD_BEEF);
    wait_bytes(1, "post_rst_wait");
    check("post_rst_stb", stb_cnt - s0, 32'd1);
    check("post_rst_adr", last_adr, 32'h7);
    check("post_rst_dat", last_dat, 32'hDEAD_BEEF);
    expect_byte("post_rst_k", 8'h4B);

    // Slave never acks
    repeat (10) @(negedge clk);
    ack_en = 1'b0;
    s0 = stb_cnt;
`ifdef UBM_BUSTIMEOUT_EN
    send_byte(8'h57, 1'b1);
    send_word(32'h0000_0009);
    send_word(32'h0000_0000);
    wait_bytes(1, "tmo_resp_wait");
    check("tmo_stb_cycles", stb_cnt - s0, 32'd8);
    check("tmo_stb_low", stb_o, 1'b0);
    expect_byte("tmo_e", 8'h45);
    repeat (4) @(negedge clk);
    check("tmo_busy_fall", busy_o, 1'b0);
`else
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0009);
    repeat (100) @(negedge clk);
    check("noack_stb_held", stb_o, 1'b1);
    check("noack_busy", busy_o, 1'b1);
    check("noack_noreply", 32'(mon_n - rd_idx), 32'd0);
    check("noack_adr", adr_o, 32'h9);
    rst_i = 1'b1;
    @(negedge clk) rst_i = 1'b0;
`endif
    ack_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
